fetch_sequencer: RTL and testbench

- Owns the processor's architectural PC, the multi-cycle state register (IF/ID/EX/MEM/WB) and the instruction register.
- Consumes next_state, PC_src and j_src from the control unit.
- Feeds opcode, mode and instruction fields back to the control unit and the datapath.
- Implements the CALL/RET return-address stack and the instruction-memory fetch handshake.

---
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, stage register, IR, return-address stack and imem fetch handshake.
// Optional FETCH_RETIRE_COUNT_EN adds retired_cnt / stall_cnt counters.
module fetch_sequencer #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      next_state,
  input  logic [1:0]      PC_src,
  input  logic            j_src,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  output logic [2:0]      state,
  output logic [5:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [15:0]     imm16,
  output logic [1:0]      mode,
  output logic [PC_W-1:0] pc_out,
`ifdef FETCH_RETIRE_COUNT_EN
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic            stack_err
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [5:0] OP_CALL = 6'b001101;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_e;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_out_q, pc_out_d;
  logic [31:0] ir_q, ir_d;
  logic [AW:0] sp_q, sp_d, sp_m1;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PC_W-1:0] ras_d [RAS_DEPTH];
  logic err_q, err_d, leave, illegal;
  logic [1:0] src;
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    ir_d     = ir_q;
    sp_d     = sp_q;
    ras_d    = ras_q;
    err_d    = err_q;
    sp_m1    = sp_q - 1'b1;
    illegal  = next_state > 3'd4;
    leave    = state_q != S_IF && (illegal || next_state == 3'd0);
    src      = illegal ? 2'd0 : PC_src;
    if (state_q == S_IF) begin
      if (imem_valid) begin
        ir_d     = imem_rdata;
        pc_out_d = pc_q;
        state_d  = S_ID;
      end
    end else begin
      state_d = illegal ? S_IF : state_e'(next_state);
      if (leave) begin
        if (src == 2'd2) pc_d = pc_out_q + PC_W'($signed(ir_q[17:2]));
        else if (src == 2'd1 && !j_src) begin
          pc_d = pc_out_q + PC_W'($signed(ir_q[25:0]));
          if (ir_q[31:26] == OP_CALL) begin
            if (sp_q == FULL) err_d = 1'b1;
            else begin
              ras_d[sp_q[AW-1:0]] = pc_out_q + PC_ONE;
              sp_d = sp_q + 1'b1;
            end
          end
        end else if (src == 2'd1) begin
          // popping an empty stack falls back to the reset vector
          if (sp_q == '0) begin
            pc_d  = RESET_PC;
            err_d = 1'b1;
          end else begin
            pc_d = ras_q[sp_m1[AW-1:0]];
            sp_d = sp_m1;
          end
        end else pc_d = pc_out_q + PC_ONE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      ir_q     <= '0;
      sp_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      ir_q     <= ir_d;
      sp_q     <= sp_d;
      err_q    <= err_d;
      ras_q    <= ras_d;
    end
  end
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d, stall_q, stall_d;
  always_comb begin
    retired_d = retired_q + {31'd0, leave};
    stall_d   = stall_q + {31'd0, state_q == S_IF && !imem_valid};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif
  assign imem_req  = state_q == S_IF && !rst;
  assign imem_addr = pc_q;
  assign state     = state_q;
  assign opcode    = ir_q[31:26];
  assign rd        = ir_q[25:22];
  assign rs1       = ir_q[21:18];
  assign rs2       = ir_q[17:14];
  assign imm16     = ir_q[17:2];
  assign mode      = ir_q[1:0];
  assign pc_out    = pc_out_q;
  assign stack_err = err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: acts as control unit and instruction memory; checks against a queue-based model.
module tb_fetch_sequencer;
  localparam logic [5:0] OP_CALL = 6'b001101, OP_RET = 6'b001110, OP_JMP = 6'b000010;
  logic clk = 0, rst = 1, j_src = 0, imem_valid = 0, imem_req, stack_err;
  logic [2:0] next_state = 0, state;
  logic [1:0] PC_src = 0, mode;
  logic [31:0] imem_addr, imem_rdata = 0, pc_out;
  logic [5:0] opcode;
  logic [3:0] rd, rs1, rs2;
  logic [15:0] imm16;
`ifdef FETCH_RETIRE_COUNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif
  int errors = 0, checks = 0;
  logic [31:0] exp_pc;
  logic exp_err;
  logic [31:0] ras[$];
  int exp_ret, exp_stall;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .next_state(next_state), .PC_src(PC_src), .j_src(j_src),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .state(state), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm16(imm16), .mode(mode),
    .pc_out(pc_out),
`ifdef FETCH_RETIRE_COUNT_EN
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
`endif
    .stack_err(stack_err));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    exp_pc = 0;
    exp_err = 0;
    ras.delete();
    exp_ret = 0;
    exp_stall = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    imem_valid = 1;
    imem_rdata = $urandom;
    tick;
    tick;
    rst = 0;
    imem_valid = 0;
    model_reset();
    #1;
  endtask

  // one instruction: fetch with waits, walk mid stages, leave to IF with src/j
  task automatic run_instr(input logic [31:0] w, input int waits, input logic [11:0] mid,
                           input int n, input bit illegal, input logic [1:0] src, input logic j);
    logic [31:0] pco;
    logic [2:0] ns;
    logic [1:0] es;
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || state !== 3'd0) begin
        errors++;
        $display("FAIL fetch req=%b addr=%h state=%0d, expected req=1 addr=%h state=0", imem_req, imem_addr, state, exp_pc);
      end
      imem_valid = i == waits;
      imem_rdata = i == waits ? w : $urandom;
      tick;
      if (i < waits) exp_stall++;
    end
    imem_valid = 0;
    pco = exp_pc;
    checks++;
    if (state !== 3'd1 || imem_req !== 1'b0 || pc_out !== pco || {opcode, rd, rs1, rs2} !== w[31:14]
        || imm16 !== w[17:2] || mode !== w[1:0]) begin
      errors++;
      $display("FAIL decode state=%0d op=%h pc_out=%h imm16=%h, expected state=1 op=%h pc_out=%h imm16=%h",
               state, opcode, pc_out, imm16, w[31:26], pco, w[17:2]);
    end
    for (int k = 0; k < n; k++) begin
      ns = mid[3*k +: 3];
      next_state = ns;
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      tick;
      checks++;
      if (state !== ns || opcode !== w[31:26]) begin
        errors++;
        $display("FAIL stage state=%0d op=%h, expected state=%0d op=%h", state, opcode, ns, w[31:26]);
      end
    end
    imem_valid = 0;
    next_state = illegal ? 3'(5 + $urandom % 3) : 3'd0;
    PC_src = src;
    j_src = j;
    tick;
    es = illegal ? 2'd0 : src;
    if (es == 2'd1 && j) begin
      if (ras.size() == 0) begin
        exp_pc = 0;
        exp_err = 1;
      end else exp_pc = ras.pop_back();
    end else if (es == 2'd1) begin
      exp_pc = pco + {{6{w[25]}}, w[25:0]};
      if (w[31:26] == OP_CALL) begin
        if (ras.size() == 8) exp_err = 1;
        else ras.push_back(pco + 1);
      end
    end else if (es == 2'd2) exp_pc = pco + {{16{w[17]}}, w[17:2]};
    else exp_pc = pco + 1;
    exp_ret++;
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b1 || imem_addr !== exp_pc || stack_err !== exp_err) begin
      errors++;
      $display("FAIL retire state=%0d req=%b addr=%h err=%b, expected state=0 req=1 addr=%h err=%b",
               state, imem_req, imem_addr, stack_err, exp_pc, exp_err);
    end
`ifdef FETCH_RETIRE_COUNT_EN
    checks++;
    if (retired_cnt !== 32'(exp_ret) || stall_cnt !== 32'(exp_stall)) begin
      errors++;
      $display("FAIL counters retired=%0d stall=%0d, expected %0d %0d", retired_cnt, stall_cnt, exp_ret, exp_stall);
    end
`endif
    next_state = 0;
    PC_src = 0;
    j_src = 0;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] d;
    d = target - exp_pc;
    run_instr({OP_JMP, d[25:0]}, 0, 12'd0, 0, 0, 2'd1, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1;
    imem_valid = 1;
    imem_rdata = 32'hFFFF_FFFF;
    next_state = 3'd2;
    tick;
    tick;
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b0 || opcode !== 6'd0 || pc_out !== 32'd0 || stack_err !== 1'b0
        || imem_addr !== 32'd0 || imm16 !== 16'd0) begin
      errors++;
      $display("FAIL reset state=%0d req=%b op=%h pc_out=%h err=%b addr=%h", state, imem_req, opcode, pc_out, stack_err, imem_addr);
    end
    rst = 0;
    imem_valid = 0;
    next_state = 0;
    model_reset();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_release req=%b, expected 1", imem_req);
    end
  endtask

  task automatic test_basic;
    run_instr(32'h0, 2, 12'({3'd4, 3'd2}), 2, 0, 2'd0, 1'b0);
    checks++;
    if (imem_addr !== 32'h1) begin
      errors++;
      $display("FAIL basic_next addr=%h, expected 00000001", imem_addr);
    end
  endtask

  task automatic test_branch;
    goto_pc(32'h10);
    run_instr({6'h04, 8'h00, 16'hFFFC, 2'b00}, 1, 12'd2, 1, 0, 2'd2, 1'b0);
    checks++;
    if (imem_addr !== 32'h0C) begin
      errors++;
      $display("FAIL branch_taken addr=%h, expected 0000000c", imem_addr);
    end
    goto_pc(32'h10);
    run_instr({6'h04, 8'h00, 16'hFFFC, 2'b00}, 1, 12'd2, 1, 0, 2'd0, 1'b0);
    checks++;
    if (imem_addr !== 32'h11) begin
      errors++;
      $display("FAIL branch_not_taken addr=%h, expected 00000011", imem_addr);
    end
  endtask

  task automatic test_call_ret;
    goto_pc(32'h20);
    run_instr({OP_CALL, 26'h40}, 0, 12'd2, 1, 0, 2'd1, 1'b0);
    checks++;
    if (imem_addr !== 32'h60) begin
      errors++;
      $display("FAIL call addr=%h, expected 00000060", imem_addr);
    end
    run_instr({OP_RET, 26'h0}, 1, 12'd2, 1, 0, 2'd1, 1'b1);
    checks++;
    if (imem_addr !== 32'h21 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL ret addr=%h err=%b, expected 00000021 0", imem_addr, stack_err);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] p0;
    p0 = exp_pc;
    for (int i = 0; i < 9; i++) begin
      run_instr({OP_CALL, 26'h100}, 0, 12'd2, 1, 0, 2'd1, 1'b0);
      checks++;
      if (stack_err !== (i == 8) || imem_addr !== p0 + 32'(i + 1) * 32'h100) begin
        errors++;
        $display("FAIL overflow_call%0d err=%b addr=%h, expected err=%b addr=%h", i, stack_err, imem_addr, i == 8, p0 + 32'(i + 1) * 32'h100);
      end
    end
    for (int k = 0; k < 9; k++) begin
      run_instr({OP_RET, 26'h0}, 0, 12'd2, 1, 0, 2'd1, 1'b1);
      checks++;
      if (imem_addr !== (k < 8 ? p0 + 32'(7 - k) * 32'h100 + 1 : 32'h0) || stack_err !== 1'b1) begin
        errors++;
        $display("FAIL underflow_ret%0d addr=%h err=%b", k, imem_addr, stack_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    goto_pc(32'h40);
    imem_valid = 1;
    imem_rdata = {OP_CALL, 26'h80};
    tick;
    imem_valid = 0;
    next_state = 3'd2;
    tick;
    rst = 1;
    imem_valid = 1;
    next_state = 3'd0;
    PC_src = 2'd1;
    tick;
    tick;
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b0 || opcode !== 6'd0 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid state=%0d req=%b op=%h err=%b", state, imem_req, opcode, stack_err);
    end
    rst = 0;
    imem_valid = 0;
    PC_src = 0;
    model_reset();
    #1;
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_addr addr=%h req=%b, expected 00000000 1", imem_addr, imem_req);
    end
    run_instr({OP_RET, 26'h0}, 0, 12'd2, 1, 0, 2'd1, 1'b1);
  endtask

  task automatic test_retire_count;
    do_reset();
    for (int i = 0; i < 5; i++) run_instr($urandom & 32'h03FF_FFFF, 1, 12'd2, 1, 0, 2'd0, 1'b0);
    checks++;
    if (imem_addr !== 32'h5) begin
      errors++;
      $display("FAIL five_instr addr=%h, expected 00000005", imem_addr);
    end
`ifdef FETCH_RETIRE_COUNT_EN
    checks++;
    if (retired_cnt !== 32'd5 || stall_cnt !== 32'd5) begin
      errors++;
      $display("FAIL count5 retired=%0d stall=%0d, expected 5 5", retired_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_random;
    logic [11:0] mid;
    logic [1:0] src;
    logic j;
    logic [5:0] op;
    logic [25:0] lo;
    int off;
    for (int t = 0; t < 80; t++) begin
      mid = 0;
      for (int k = 0; k < 4; k++) mid[3*k +: 3] = 3'(2 + $urandom % 3);
      src = 2'($urandom);
      j = 1'($urandom);
      off = int'($urandom_range(0, 511)) - 256;
      lo = 26'($urandom);
      op = 6'($urandom);
      if (src == 2'd1 && j) op = OP_RET;
      else if (src == 2'd1) begin
        op = $urandom % 2 ? OP_CALL : OP_JMP;
        lo = 26'(off);
      end
      run_instr({op, lo}, $urandom % 4, mid, $urandom % 4, $urandom % 6 == 0, src, j);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_call_ret();
    test_overflow();
    test_reset_mid();
    test_retire_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
